// File: rtl/uart_tx.sv
// uart_tx: byte FIFO feeding an 8N1 serial transmitter (start, 8 data LSB first, stop).
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   wr_en    - push wr_data into the FIFO (dropped when full)
//   wr_data  - byte to queue
//   full     - FIFO holds 2^FIFO_DEPTH_LOG2 bytes
//   count    - number of bytes queued
//   busy     - frame in progress or bytes pending
//   tx       - registered serial line, idle high
module uart_tx #(
    parameter int unsigned BAUD_DIV        = 868,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       full,
    output logic [FIFO_DEPTH_LOG2:0]   count,
    output logic                       busy,
    output logic                       tx
);

    localparam int unsigned PW    = FIFO_DEPTH_LOG2;
    localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned BW    = 16;
    localparam int unsigned DEPTH = 32'd1 << FIFO_DEPTH_LOG2;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            busy_q, busy_d;
    logic            tx_q, tx_d;
    logic            push, pop, has_data;
    logic [7:0]      mem_q [DEPTH];

    assign full  = full_q;
    assign count = count_q;
    assign busy  = busy_q;
    assign tx    = tx_q;

    // Next-state: frame sequencing, FIFO pointer/count update and registered outputs.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        pop      = 1'b0;
        push     = wr_en && !full_q;
        has_data = (count_q != '0);

        case (state_q)
            IDLE: begin
                if (has_data) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = BAUD_RELOAD;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    baud_d  = BAUD_RELOAD;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more data is waiting.
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (has_data) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d = mem_q[rd_q];
            rd_d    = rd_q + PW'(1);
        end
        if (push) begin
            wr_d = wr_q + PW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);
        full_d  = (count_d == CW'(DEPTH));
        busy_d  = (state_d != IDLE) || (count_d != '0);

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            full_q  <= full_d;
            busy_q  <= busy_d;
            tx_q    <= tx_d;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx (BAUD_DIV=4, depth 4): queue/frame-timeline model, per-cycle
// compare, serial decoder on tx, directed scenarios plus random traffic.
module tb_uart_tx;

    localparam int unsigned BD    = 4;
    localparam int unsigned LOG2  = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * BD;

    logic            clk;
    logic            rst;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            full;
    logic [LOG2:0]   count;
    logic            busy;
    logic            tx;

    uart_tx #(.BAUD_DIV(BD), .FIFO_DEPTH_LOG2(LOG2)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .count   (count),
        .busy    (busy),
        .tx      (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model: pending bytes, plus position inside the frame currently on the wire.
    logic [7:0] mq[$];
    logic [7:0] m_sent[$];
    logic [7:0] m_byte;
    bit         m_active;
    int         m_pos;

    // Decoded bytes seen on tx.
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    bit         rx_on;
    int         rx_cnt;
    logic [7:0] rx_sh;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_active = 1'b0;
        m_pos    = 0;
        m_byte   = 8'h00;
    endtask

    // One rising edge of the model, using occupancy as it was before the edge.
    task automatic model_edge(input logic we, input logic [7:0] d);
        int pre;
        bit ended;
        pre   = mq.size();
        ended = 1'b0;
        if (m_active) begin
            if (m_pos == FRAME - 1) ended = 1'b1;
            else m_pos++;
        end
        if ((!m_active || ended) && pre > 0) begin
            m_byte   = mq.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
            m_sent.push_back(m_byte);
        end else if (ended) begin
            m_active = 1'b0;
        end
        if (we && pre < int'(DEPTH)) mq.push_back(d);
    endtask

    function automatic logic exp_tx();
        int k;
        if (!m_active) return 1'b1;
        k = m_pos / BD;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("tx", 32'(tx), 32'(exp_tx()));
            check("count", 32'(count), 32'(mq.size()));
            check("full", 32'(full), 32'(mq.size() == int'(DEPTH)));
            check("busy", 32'(busy), 32'(m_active || mq.size() > 0));
        end
    end

    // Serial decoder: mid-bit sampling of the DUT line.
    always @(negedge clk) begin
        if (rst || !cmp_en) begin
            rx_on  = 1'b0;
            rx_cnt = 0;
        end else if (!rx_on) begin
            if (tx == 1'b0) begin
                rx_on  = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if ((rx_cnt % BD) == 2 && rx_cnt / BD >= 1 && rx_cnt / BD <= 8)
                rx_sh[rx_cnt / BD - 1] = tx;
            if (rx_cnt == 9 * BD + 2) begin
                check("stop_bit", 32'(tx), 32'd1);
                rx_q.push_back(rx_sh);
            end
            if (rx_cnt == FRAME - 1) rx_on = 1'b0;
        end
    end

    task automatic step(input logic we, input logic [7:0] d);
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        model_edge(we, d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_active || mq.size() > 0) && n < 2000) begin
            step(1'b0, 8'h00);
            n++;
        end
        if (n >= 2000) check("drain_timeout", 32'd1, 32'd0);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
    endtask

    task automatic wait_stop_end();
        int n;
        n = 0;
        while (!(m_active && m_pos == FRAME - 1) && n < 200) begin
            step(1'b0, 8'h00);
            n++;
        end
        if (n >= 200) check("stop_wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_rx(input string name);
        check({name, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check(name, 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    logic [FRAME-1:0]   cap;
    logic [2*FRAME-1:0] cap2;
    logic [9:0]         bits55;
    int                 bad;
    int                 busy_lo;
    int                 n;

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        cmp_en = 1'b1;
        rst    = 1'b0;
        step(1'b0, 8'h00);

        // Single byte 0x55: start 0, data 1,0,1,0,1,0,1,0, stop 1.
        rx_q.delete();
        bits55 = 10'b1010101010;
        step(1'b1, 8'h55);
        check("single_count1", 32'(count), 32'd1);
        check("single_tx_idle", 32'(tx), 32'd1);
        for (int i = 0; i < int'(FRAME); i++) begin
            step(1'b0, 8'h00);
            cap[i] = tx;
        end
        bad = 0;
        for (int i = 0; i < int'(FRAME); i++)
            if (cap[i] !== bits55[i / BD]) bad++;
        check("frame_55_bits", 32'(bad), 32'd0);
        step(1'b0, 8'h00);
        check("single_busy_end", 32'(busy), 32'd0);
        exp_q = '{8'h55};
        check_rx("rx_single");

        // Back-to-back 0xA3, 0x0F.
        rx_q.delete();
        step(1'b1, 8'hA3);
        step(1'b1, 8'h0F);
        cap2[0] = tx;
        busy_lo = (busy == 1'b1) ? 0 : 1;
        for (int i = 1; i < int'(2 * FRAME); i++) begin
            step(1'b0, 8'h00);
            cap2[i] = tx;
            if (busy !== 1'b1) busy_lo++;
        end
        check("b2b_first_start", 32'(cap2[0]), 32'd0);
        check("b2b_stop1", 32'(cap2[FRAME-1]), 32'd1);
        check("b2b_no_gap", 32'(cap2[FRAME]), 32'd0);
        check("b2b_busy_low_cycles", 32'(busy_lo), 32'd0);
        step(1'b0, 8'h00);
        check("b2b_busy_end", 32'(busy), 32'd0);
        exp_q = '{8'hA3, 8'h0F};
        check_rx("rx_b2b");

        // Full / drop, then writes on the stop-end pop edge.
        rx_q.delete();
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
        check("full_count", 32'(count), 32'd4);
        check("full_flag", 32'(full), 32'd1);
        wait_stop_end();
        step(1'b1, 8'h77);
        check("pop_full_drop_count", 32'(count), 32'd3);
        check("pop_full_drop_full", 32'(full), 32'd0);
        wait_stop_end();
        step(1'b1, 8'h88);
        check("pop_push_count", 32'(count), 32'd3);
        drain();
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h88};
        check_rx("rx_full");

        // Reset in bit 3 of 0xFF with a byte still pending.
        rx_q.delete();
        step(1'b1, 8'hFF);
        step(1'b1, 8'h11);
        n = 0;
        while (!(m_active && m_pos >= 4 * BD && m_pos < 5 * BD) && n < 200) begin
            step(1'b0, 8'h00);
            n++;
        end
        if (n >= 200) check("bit3_wait_timeout", 32'd1, 32'd0);
        @(posedge clk);
        model_edge(1'b0, 8'h00);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rstmid_tx", 32'(tx), 32'd1);
        check("rstmid_count", 32'(count), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_full", 32'(full), 32'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        step(1'b1, 8'h80);
        check("post_rst_count", 32'(count), 32'd1);
        drain();
        exp_q = '{8'h80};
        check_rx("rx_after_rst");

        // Pointer wrap: 12 bytes through the depth-4 FIFO.
        rx_q.delete();
        n = 0;
        while (n < 12) begin
            if (mq.size() < int'(DEPTH)) begin
                step(1'b1, 8'(8'h10 + n));
                n++;
            end else begin
                step(1'b0, 8'h00);
            end
        end
        drain();
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(8'(8'h10 + i));
        check_rx("rx_wrap");

        // Random traffic, including writes while full.
        rx_q.delete();
        m_sent.delete();
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 11) == 0), 8'($urandom));
        drain();
        exp_q = m_sent;
        check_rx("rx_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
